// File: rtl/eth_pkg.sv
// Shared constants, state type and helpers for the Ethernet receive path.
package eth_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [10:0] MIN_FRAME     = 11'd18;
  localparam logic [10:0] MAX_FRAME     = 11'd1518;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

  // Byte offsets from the first destination-MAC byte.
  localparam logic [10:0] DST_OFF   = 11'd0;
  localparam logic [10:0] SRC_OFF   = 11'd6;
  localparam logic [10:0] ETYPE_OFF = 11'd12;
  localparam logic [10:0] PAY_OFF   = 11'd14;

  typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, DROP} rx_state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Network-order byte idx (0 = first on the wire) of a MAC address.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] s;
    s = mac >> (8 * (5 - int'(idx)));
    return s[7:0];
  endfunction
endpackage

// File: rtl/eth_rx_crc32.sv
// Reflected CRC-32 advanced one LSB-first chunk per enabled cycle; flags the good-FCS residue.
module eth_rx_crc32
  import eth_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic         match
);
  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  logic [31:0] crc;

  function automatic logic [31:0] step(input logic [31:0] c, input logic [N-1:0] dd);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < N; i++) r = {1'b0, r[31:1]} ^ ((r[0] ^ dd[i]) ? POLY_R : 32'h0);
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     crc <= '1;
    else if (clr) crc <= '1;
    else if (en)  crc <= step(crc, d);
  end

  assign match = (crc == CRC_RESIDUE);
endmodule

// File: rtl/ethernet_rx.sv
// Ethernet receive path: preamble/SFD lock, header parse, 4-byte hold-back payload FIFO, FCS verdict.
// Define ETHERNET_RX_BCAST_EN to also accept frames addressed to ff:ff:ff:ff:ff:ff.
module ethernet_rx
  import eth_pkg::*;
#(
  parameter int N = 2  // 2 or 4 only
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] axiid,
  input  logic         axiiv,
  input  logic [47:0]  my_mac,
  output logic         axiov,
  output logic [7:0]   axiod,
  output logic [47:0]  src_mac,
  output logic [15:0]  etype,
  output logic         frame_done,
  output logic         frame_ok
);
`ifdef ETHERNET_RX_BCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif
  localparam int         CPB        = 8 / N;
  localparam logic [1:0] LAST_CHUNK = 2'(CPB - 1);

  rx_state_t   state;
  logic [7:0]  sr;
  logic [1:0]  ccnt;
  logic [10:0] bcnt;
  logic        m_ok, b_ok;
  logic [7:0]  hold [4];
  logic [2:0]  hcnt;
  logic        crc_ok;
  logic [7:0]  nb;
  logic        last, dest_hit, bcast_hit, addr_ok;
  logic [2:0]  didx;

  assign nb        = {axiid, sr[7:N]};
  assign last      = (ccnt == LAST_CHUNK);
  assign didx      = 3'(bcnt - DST_OFF);
  assign dest_hit  = m_ok && (nb == mac_byte(my_mac, didx));
  assign bcast_hit = b_ok && (nb == mac_byte(BCAST_MAC, didx));
  assign addr_ok   = dest_hit || (BCAST_EN && bcast_hit);

  eth_rx_crc32 #(.N(N)) u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE || state == PRE),
    .en   (axiiv && (state == HDR || state == PAY)),
    .d    (axiid),
    .match(crc_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sr         <= '0;
      ccnt       <= '0;
      bcnt       <= '0;
      m_ok       <= 1'b0;
      b_ok       <= 1'b0;
      hold       <= '{default: '0};
      hcnt       <= '0;
      axiov      <= 1'b0;
      axiod      <= '0;
      src_mac    <= '0;
      etype      <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
    end else begin
      axiov      <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      if (!axiiv) begin
        if (state == HDR || state == PAY || state == DROP) begin
          frame_done <= 1'b1;
          frame_ok   <= (state == PAY) && crc_ok && (ccnt == 2'd0) &&
                        (bcnt >= MIN_FRAME) && (bcnt <= MAX_FRAME);
        end
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (axiid == PREAMBLE_BYTE[N-1:0]) state <= PRE;
          PRE: begin
            if (axiid == SFD_BYTE[7:8-N]) begin
              state <= HDR;
              ccnt  <= '0;
              bcnt  <= '0;
              hcnt  <= '0;
              m_ok  <= 1'b1;
              b_ok  <= 1'b1;
            end else if (axiid != PREAMBLE_BYTE[N-1:0]) begin
              state <= IDLE;
            end
          end
          HDR, PAY: begin
            sr   <= nb;
            ccnt <= last ? 2'd0 : ccnt + 2'd1;
            if (last) begin
              bcnt <= bcnt + 11'd1;
              if (state == HDR) begin
                if (bcnt < SRC_OFF) begin
                  m_ok <= dest_hit;
                  b_ok <= bcast_hit;
                  if (bcnt == SRC_OFF - 11'd1 && !addr_ok) state <= DROP;
                end else if (bcnt < ETYPE_OFF) begin
                  src_mac <= {src_mac[39:0], nb};
                end else begin
                  etype <= {etype[7:0], nb};
                  if (bcnt == PAY_OFF - 11'd1) state <= PAY;
                end
              end else if (bcnt == MAX_FRAME) begin
                state <= DROP;
              end else if (hcnt == 3'd4) begin
                // FIFO full: the oldest byte is now known not to be FCS
                axiov <= 1'b1;
                axiod <= hold[0];
                hold  <= '{hold[1], hold[2], hold[3], nb};
              end else begin
                hold[hcnt[1:0]] <= nb;
                hcnt            <= hcnt + 3'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
